// File: rtl/seg_scan_ctrl_if.sv
// Register-side and pin-side signals of the seven-segment scan controller.
// The master drives display content; the slave (the controller) drives the pins.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DUTY_BITS  = 4
);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] number;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [DUTY_BITS-1:0]    brightness;
    logic                    lz_suppress;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [7:0]              cathodes;
    logic [IW-1:0]           scan_index;
    logic                    frame_done;

    modport master (
        output number, dp_in, blank_mask, brightness, lz_suppress,
        input  anodes, cathodes, scan_index, frame_done
    );

    modport slave (
        input  number, dp_in, blank_mask, brightness, lz_suppress,
        output anodes, cathodes, scan_index, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM brightness, blanking,
// decimal points, leading-zero suppression and frame-coherent input capture.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int STEP_CYCLES = 12500,
    parameter int DUTY_BITS   = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic          clk,
    input  logic          reset,
    seg_scan_ctrl_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic AL = (ACTIVE_LOW != 0);

    logic [PW-1:0]           r_presc;
    logic [DUTY_BITS-1:0]    r_step;
    logic [IW-1:0]           r_idx;
    logic                    r_frame_done;

    logic [4*NUM_DIGITS-1:0] r_sh_number;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic [DUTY_BITS-1:0]    r_sh_bright;
    logic                    r_sh_lz;

    logic [NUM_DIGITS-1:0]   r_anodes;
    logic [7:0]              r_cathodes;

    logic                    w_presc_wrap;
    logic                    w_step_wrap;
    logic                    w_frame_wrap;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_zero_run;
    logic [3:0]              w_nib;
    logic [7:0]              w_seg;
    logic                    w_step_lit;
    logic                    w_on;
    logic [NUM_DIGITS-1:0]   w_onehot;

    function automatic logic [7:0] f_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0:    g = 8'b0000_0011;
            4'h1:    g = 8'b1001_1111;
            4'h2:    g = 8'b0010_0101;
            4'h3:    g = 8'b0000_1101;
            4'h4:    g = 8'b1001_1001;
            4'h5:    g = 8'b0100_1001;
            4'h6:    g = 8'b0100_0001;
            4'h7:    g = 8'b0001_1111;
            4'h8:    g = 8'b0000_0001;
            4'h9:    g = 8'b0000_1001;
            4'hA:    g = 8'b0001_0001;
            4'hB:    g = 8'b1100_0001;
            4'hC:    g = 8'b0110_0011;
            4'hD:    g = 8'b1000_0101;
            4'hE:    g = 8'b0110_0001;
            default: g = 8'b0111_0001;
        endcase
        return g;
    endfunction

    assign w_presc_wrap = (r_presc == P_LAST);
    assign w_step_wrap  = (r_step == {DUTY_BITS{1'b1}});
    assign w_frame_wrap = w_presc_wrap && w_step_wrap && (r_idx == I_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_step       <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_presc_wrap ? '0 : r_presc + PW'(1);
            r_frame_done <= w_frame_wrap;
            if (w_presc_wrap) begin
                r_step <= r_step + DUTY_BITS'(1);
                if (w_step_wrap) begin
                    r_idx <= (r_idx == I_LAST) ? '0 : r_idx + IW'(1);
                end
            end
        end
    end

    // Inputs are sampled only at the frame wrap so a frame is never torn.
    always_ff @(posedge clk) begin
        if (reset || w_frame_wrap) begin
            r_sh_number <= bus.number;
            r_sh_dp     <= bus.dp_in;
            r_sh_blank  <= bus.blank_mask;
            r_sh_bright <= bus.brightness;
            r_sh_lz     <= bus.lz_suppress;
        end
    end

    always_comb begin
        w_supp     = '0;
        w_zero_run = r_sh_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (r_sh_number[4*i +: 4] == 4'h0);
            w_supp[i]  = w_zero_run;
        end
    end

    assign w_nib      = r_sh_number[{r_idx, 2'b00} +: 4];
    assign w_onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    // Step 0 stays dark to hide ghosting while the anode switches.
    assign w_step_lit = (r_step != '0) && (r_step <= r_sh_bright);
    assign w_on       = w_step_lit && !r_sh_blank[r_idx]
                        && (!w_supp[r_idx] || r_sh_dp[r_idx]);

    always_comb begin
        w_seg    = w_supp[r_idx] ? 8'hFF : f_glyph(w_nib);
        w_seg[0] = !r_sh_dp[r_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_anodes   <= {NUM_DIGITS{AL}};
            r_cathodes <= {8{AL}};
        end else if (w_on) begin
            r_anodes   <= w_onehot ^ {NUM_DIGITS{AL}};
            r_cathodes <= w_seg ^ {8{!AL}};
        end else begin
            r_anodes   <= {NUM_DIGITS{AL}};
            r_cathodes <= {8{AL}};
        end
    end

    assign bus.anodes     = r_anodes;
    assign bus.cathodes   = r_cathodes;
    assign bus.scan_index = r_idx;
    assign bus.frame_done = r_frame_done;
endmodule
